// File: rtl/wr_modport.sv
// rtl/wr_modport.sv - 32x32 synchronous FIFO exposing write-side status (full, almost-full, overflow, count, level).
// Optional macro FIFO_MEM_RST_EN adds mem_rst, which zeroes storage without touching pointers or counters.
module wr_modport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  wclk,
  input  logic                  sw_rst,
`ifdef FIFO_MEM_RST_EN
  input  logic                  mem_rst,
`endif
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] afull_value,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  underflow,
  output logic                  wfull,
  output logic                  wr_almost_ful,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   fifo_write_count,
  output logic [ADDR_WIDTH:0]   wr_level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_acc, rd_acc;
  logic                  mem_clr;

`ifdef FIFO_MEM_RST_EN
  assign mem_clr = mem_rst;
`else
  assign mem_clr = 1'b0;
`endif

  assign wfull         = (level_q == FULL_LEVEL);
  assign rempty        = (level_q == '0);
  assign wr_almost_ful = (level_q >= {1'b0, afull_value});

  // Requests seen in a reset cycle never reach storage or pointers.
  assign wr_acc = write_enable & ~wfull & ~sw_rst & ~mem_clr;
  assign rd_acc = read_enable & ~rempty & ~sw_rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wcount_d = wcount_q;
    rdata_d  = rdata_q;
    ovf_d    = write_enable & wfull;
    unf_d    = read_enable & rempty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      wcount_d = wcount_q + LVL_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (sw_rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      wcount_d = '0;
      rdata_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
    wcount_q <= wcount_d;
    rdata_q  <= rdata_d;
    ovf_q    <= ovf_d;
    unf_q    <= unf_d;
  end

  // Storage is deliberately outside the sw_rst domain.
  always_ff @(posedge wclk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata            = rdata_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;
  assign fifo_write_count = wcount_q;
  assign wr_level         = level_q;

endmodule

// File: tb/tb_wr_modport.sv
// tb/tb_wr_modport.sv - scoreboard bench for wr_modport against a queue-based FIFO model.
module tb_wr_modport;

  logic        wclk = 1'b0;
  logic        sw_rst = 1'b1;
  logic [31:0] wdata = '0;
  logic        write_enable = 1'b0;
  logic [4:0]  afull_value = 5'd20;
  logic        read_enable = 1'b0;
  logic [31:0] rdata;
  logic        rempty, underflow, wfull, wr_almost_ful, overflow;
  logic [5:0]  fifo_write_count, wr_level;
`ifdef FIFO_MEM_RST_EN
  logic        mem_rst = 1'b0;
`endif

  wr_modport dut (
    .wclk(wclk), .sw_rst(sw_rst),
`ifdef FIFO_MEM_RST_EN
    .mem_rst(mem_rst),
`endif
    .wdata(wdata), .write_enable(write_enable), .afull_value(afull_value),
    .read_enable(read_enable), .rdata(rdata), .rempty(rempty), .underflow(underflow),
    .wfull(wfull), .wr_almost_ful(wr_almost_ful), .overflow(overflow),
    .fifo_write_count(fifo_write_count), .wr_level(wr_level)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int          level;
    int          count;
    logic        ovf;
    logic        unf;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_data[$];
  int          m_count = 0;
  logic [31:0] m_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock: apply inputs, let the edge happen, advance the model, queue what should be visible.
  task automatic step(input logic we, input logic [31:0] wd, input logic re,
                      input logic rst, input logic mrst);
    exp_t e;
    logic full, empty, eff_mrst;
    write_enable = we;
    wdata        = wd;
    read_enable  = re;
    sw_rst       = rst;
`ifdef FIFO_MEM_RST_EN
    mem_rst      = mrst;
    eff_mrst     = mrst;
`else
    eff_mrst     = 1'b0;
`endif
    @(posedge wclk);
    full  = (m_data.size() == 32);
    empty = (m_data.size() == 0);
    if (rst) begin
      m_data.delete();
      m_count = 0;
      m_rdata = '0;
      e.ovf = 1'b0;
      e.unf = 1'b0;
    end else begin
      e.ovf = we & full;
      e.unf = re & empty;
      if (re && !empty) m_rdata = m_data.pop_front();
      if (eff_mrst) foreach (m_data[i]) m_data[i] = '0;
      if (we && !full && !eff_mrst) begin
        m_data.push_back(wd);
        m_count = (m_count + 1) % 64;
      end
    end
    e.level = m_data.size();
    e.count = m_count;
    e.rdata = m_rdata;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge wclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_level", wr_level, e.level);
      chk("fifo_write_count", fifo_write_count, e.count);
      chk("wfull", wfull, e.level == 32);
      chk("rempty", rempty, e.level == 0);
      chk("wr_almost_ful", wr_almost_ful, e.level >= int'(afull_value));
      chk("overflow", overflow, e.ovf);
      chk("underflow", underflow, e.unf);
      chk("rdata", rdata, e.rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge wclk);
    #1;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Fill, almost-full crossing at 20, full at 32, then one rejected write.
    for (int i = 0; i < 32; i++) step(1, 32'h1000 + i, 0, 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Full with simultaneous read: write rejected, read proceeds.
    step(1, 32'hBAD0_0001, 1, 0, 0);
    step(1, 32'h1020, 0, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Empty with simultaneous write: read rejected.
    step(1, 32'h2000, 1, 0, 0);
    for (int i = 1; i < 10; i++) step(1, 32'h2000 + i, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h3000 + i, 1, 0, 0);
    step(1, 32'h4000, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // afull_value of zero asserts almost-full even when empty.
    afull_value = 5'd0;
    step(0, 0, 0, 0, 0);
    afull_value = 5'd31;
    for (int i = 0; i < 32; i++) step(1, 32'h5000 + i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef FIFO_MEM_RST_EN
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 32'h6000 + i, 0, 0, 0);
    step(1, 32'h6666_6666, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h7000 + i, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
`endif
    // Random traffic with varying bias; carries the write counter through several wraps.
    for (int i = 0; i < 1500; i++) begin
      int wbias;
      logic we, re, rst, mrst;
      wbias = ((i / 100) % 2 == 0) ? 70 : 30;
      we   = ($urandom_range(99) < wbias);
      re   = ($urandom_range(99) < 100 - wbias);
      rst  = ($urandom_range(199) == 0);
      mrst = ($urandom_range(149) == 0);
      if ($urandom_range(49) == 0) afull_value = 5'($urandom);
      step(we, $urandom, re, rst, mrst);
    end
    step(0, 0, 0, 0, 0);
    @(negedge wclk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wr_modport.md
Name: wr_modport

Overview:
- Single-clock synchronous FIFO: 32-bit data path, 32 entries.
- The write-side status set is the block's primary interface: full, programmable almost-full, overflow, write count and level.
- A minimal read port drains the FIFO.
- Sits behind the write-side agent interface of the FIFO subsystem. All logic is on one clock.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata.
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH = 32.

Ports:
- wclk  input  1  clock; all state updates on posedge.
- sw_rst  input  1  synchronous active-high reset.
- wdata  input  DATA_WIDTH  write data.
- write_enable  input  1  write request.
- afull_value  input  ADDR_WIDTH  almost-full threshold.
- read_enable  input  1  read request.
- rdata  output  DATA_WIDTH  read data, registered.
- rempty  output  1  FIFO empty.
- underflow  output  1  one-cycle pulse: read attempted while empty.
- wfull  output  1  FIFO full.
- wr_almost_ful  output  1  level >= afull_value.
- overflow  output  1  one-cycle pulse: write attempted while full.
- fifo_write_count  output  ADDR_WIDTH+1  accepted-write counter, wraps modulo 64.
- wr_level  output  ADDR_WIDTH+1  current occupancy, 0..32.

Behaviour:
- Reset (sw_rst=1 at posedge; has priority over all requests):
  - wr_ptr, rd_ptr, wr_level, fifo_write_count cleared to 0.
  - overflow, underflow, rdata cleared to 0.
  - After reset: rempty=1, wfull=0. wr_almost_ful=1 only if afull_value==0.
  - Storage contents are not cleared (see Optional Feature).
- Flags are combinational from registered state:
  - wfull = (wr_level==32).
  - rempty = (wr_level==0).
  - wr_almost_ful = (wr_level >= afull_value). Unsigned compare, 6-bit level vs zero-extended threshold. afull_value is sampled live, not latched.
- Write acceptance: wr_acc = write_enable & ~wfull, using the pre-edge flag.
  - On wr_acc: mem[wr_ptr[4:0]] <= wdata; wr_ptr++ (wraps 31->0); fifo_write_count++ (wraps 63->0).
- Read acceptance: rd_acc = read_enable & ~rempty.
  - On rd_acc: rdata <= mem[rd_ptr]; rd_ptr++ (wraps).
  - rdata is valid the cycle after the request and holds its value otherwise.
- Level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Full with simultaneous read: the write is rejected (wfull gates it). The read proceeds; level becomes 31. overflow pulses.
- Empty with simultaneous write: the read is rejected. The write proceeds; level becomes 1. underflow pulses.
- overflow <= write_enable & wfull, registered: high exactly one cycle after each rejected write, otherwise 0.
- underflow <= read_enable & rempty, same timing rule.
- Level/flag latency: wr_level, wfull, wr_almost_ful reflect an accepted write in the cycle following its posedge.
- Reset mid-operation: any in-flight request in the reset cycle is discarded. The FIFO reads as empty afterward; previously stored data is not returned.
- No X propagation: the read path never indexes outside 0..31.

Optional Feature:
- Macro FIFO_MEM_RST_EN.
- When defined:
  - Extra input mem_rst (1 bit, synchronous active-high).
  - While mem_rst=1 at posedge, all 32 storage entries are written 0.
  - Pointers, counters and flags are unaffected unless sw_rst is also high.
  - Writes in that cycle are dropped; fifo_write_count does not increment.
- When undefined:
  - No mem_rst port.
  - Storage holds its previous contents across sw_rst.

Test Plan:
- Reset: sw_rst=1 for 2 cycles, afull_value=20 -> wr_level=0, fifo_write_count=0, rempty=1, wfull=0, wr_almost_ful=0, overflow=0.
- Fill and almost-full: 32 consecutive writes of 0x1000+i -> wr_almost_ful rises the cycle after the 20th write (level 20); after write 32, wfull=1, wr_level=32, fifo_write_count=32.
- Overflow: 33rd write while full -> overflow=1 for exactly one cycle; wr_level stays 32; fifo_write_count stays 32; stored data unchanged.
- Drain and underflow:
  - 32 reads -> rdata sequence 0x1000..0x101F in order, each one cycle after its read.
  - Then rempty=1.
  - An extra read pulses underflow once; rdata holds 0x101F.
- Simultaneous ops:
  - At level 10, write_enable=read_enable=1 for 5 cycles -> wr_level stays 10; fifo_write_count +5.
  - Then sw_rst mid-stream -> level 0, rempty=1.
- Counter wrap: 64 accepted writes across fill/drain cycles -> fifo_write_count returns to 0 while wr_level is correct. Also run with FIFO_MEM_RST_EN: mem_rst pulse, then write/read confirms cleared entries read 0 only where not rewritten.
